spi_master_param: RTL
=====================

Name: spi_master_param

Overview:
- Parametrised next-generation SPI master for the SPI top level; successor to the fixed 32-bit, single-mode, single-slave master.
- Adds generic word width, programmable SCLK divider, all four SPI modes (CPOL/CPHA), MSB/LSB-first ordering, multiple chip selects and a busy/done handshake.
- Sits between the user-side start/data interface and the SPI pins; one full-duplex word per transfer.

Parameters:
- DATA_WIDTH, 32: bits per transfer, >=2.
- CLK_DIV, 2: clk cycles per SCLK half-period, >=1.
- NUM_CS, 1: number of chip-select outputs, >=1.
- CS_SEL_W, ($clog2(NUM_CS) > 0 ? $clog2(NUM_CS) : 1): width of cs_sel.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  transfer request, sampled only in IDLE.
- cpol  in  1  SCLK idle level; latched at start.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at start.
- lsb_first  in  1  1 = LSB shifted first; latched at start.
- cs_sel  in  CS_SEL_W  slave index; latched at start.
- data_in  in  DATA_WIDTH  TX word; latched at start.
- data_out  out  DATA_WIDTH  RX word; updated only in DONE.
- busy  out  1  high from the cycle after start acceptance until DONE, inclusive.
- done  out  1  one-cycle pulse marking the end of a transfer.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.
- SCLK  out  1  serial clock.
- CS  out  NUM_CS  active-low chip selects; one-hot-low during a transfer.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; data_out=0; busy=0; done=0; MOSI=0; SCLK=0; CS all 1; counters and shift registers cleared. Mid-transfer reset aborts immediately. No done pulse is produced and data_out is not updated.
- All outputs are registered.
- FSM states: IDLE, SETUP, TRANSFER, HOLD, DONE.
- IDLE:
  - SCLK = latched cpol (0 after reset).
  - start=1 at cycle 0 latches cpol, cpha, lsb_first, cs_sel and data_in, then moves to SETUP.
- SETUP (cycles 1..CLK_DIV):
  - busy=1; CS[cs_sel]=0.
  - If cs_sel>=NUM_CS, CS[0] is used.
  - SCLK=cpol.
  - cpha=0: first bit already driven on MOSI.
  - cpha=1: MOSI holds 0 until the first edge.
- TRANSFER:
  - 2*DATA_WIDTH SCLK half-periods of CLK_DIV cycles each.
  - Edge k (1..2*DATA_WIDTH) toggles SCLK at the end of half-period k-1.
  - cpha=0: sample MISO on odd edges; shift the next bit out on even edges, except the final edge.
  - cpha=1: shift out on odd edges; sample on even edges.
  - Bit order is MSB first unless lsb_first=1.
  - RX bits are assembled in the same order as TX bits, so the word is not reversed.
- HOLD: CLK_DIV cycles; SCLK=cpol; CS held low.
- DONE: one cycle.
  - CS all 1; done=1; busy=1; data_out = assembled RX word.
  - Next state is IDLE; busy=0 in IDLE.
- Timing: done is asserted at cycle 1 + CLK_DIV*(2*DATA_WIDTH+2) after the start cycle.
- start held high: the next transfer is accepted in the IDLE cycle after DONE, giving at least one IDLE cycle between transfers with CS high.
- start while busy: ignored. Input changes while busy are ignored because all inputs are latched.
- MISO is sampled directly with no synchroniser; the integrator ensures timing.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit, latched at start). When the latched value is 1, the receive path samples internal MOSI instead of MISO, so data_out equals data_in. The pins behave unchanged.
- Undefined: the port is absent and the receive path always uses MISO.

Test Plan:
1. DATA_WIDTH=8, CLK_DIV=2, mode 0, MSB-first, data_in=8'hA5, MISO tied to MOSI:
   - MOSI sequence is 1,0,1,0,0,1,0,1.
   - done is asserted at cycle 37 after start.
   - data_out=8'hA5; 8 rising SCLK edges observed.
2. Mode 3 (cpol=1, cpha=1), data_in=8'h3C, slave model returns 8'hC3:
   - SCLK idles high.
   - MOSI changes on falling edges; data_out=8'hC3.
3. lsb_first=1, data_in=8'h01, MISO returns 8'h80 LSB-first:
   - MOSI first bit is 1, then seven 0s.
   - data_out=8'h80.
4. NUM_CS=4, cs_sel=2:
   - CS=4'b1011 from SETUP through HOLD.
   - CS=4'b1111 in DONE and IDLE.
5. Reset pulse at cycle 10 of a transfer:
   - CS=all 1 and busy=0 immediately.
   - No done pulse; data_out unchanged (0).
   - The next start completes normally.
6. start held high for three transfers with data_in changed mid-transfer:
   - Each word is latched only at acceptance.
   - Three done pulses, each followed by at least one cycle with CS high.
   - start pulses during busy are ignored.

Source files
------------

// File: rtl/spi_master_param.sv
// ---------------------------------------------------------------------------
// spi_master_param
//
// Parametrised SPI master. Each transfer moves one full-duplex word of
// DATA_WIDTH bits. SPI mode (cpol/cpha), bit order and slave select are
// latched when a transfer is accepted, so input changes during a transfer
// have no effect.
//
// Sequence per transfer:
//   IDLE -> SETUP (CLK_DIV cycles) -> TRANSFER (2*DATA_WIDTH half-periods of
//   CLK_DIV cycles) -> HOLD (CLK_DIV cycles) -> DONE (1 cycle) -> IDLE
//
// Optional build macro: SPI_LOOPBACK_EN adds a 'loopback' input. When the
// value latched at start is 1, the receive path samples the internal MOSI
// register instead of the MISO pin. The pins themselves behave unchanged.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   start      transfer request, sampled only in IDLE
//   cpol       SCLK idle level (latched at start)
//   cpha       0: sample on leading edge, 1: sample on trailing edge (latched)
//   lsb_first  1: LSB shifted first (latched)
//   cs_sel     slave index; out-of-range values select CS[0] (latched)
//   data_in    TX word (latched)
//   loopback   (SPI_LOOPBACK_EN only) internal MOSI->RX loop (latched)
//   data_out   RX word, updated only in DONE
//   busy       high from SETUP through DONE
//   done       one-cycle pulse in DONE
//   MOSI/MISO  serial data out / in (MISO is not synchronised)
//   SCLK       serial clock
//   CS         active-low chip selects, one-hot-low during a transfer
// ---------------------------------------------------------------------------
module spi_master_param #(
  parameter int DATA_WIDTH = 32,
  parameter int CLK_DIV    = 2,
  parameter int NUM_CS     = 1,
  parameter int CS_SEL_W   = ($clog2(NUM_CS) > 0 ? $clog2(NUM_CS) : 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [CS_SEL_W-1:0]   cs_sel,
  input  logic [DATA_WIDTH-1:0] data_in,
`ifdef SPI_LOOPBACK_EN
  input  logic                  loopback,
`endif
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic                  SCLK,
  output logic [NUM_CS-1:0]     CS
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HALF_W = $clog2(2 * DATA_WIDTH);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_TRANSFER,
    S_HOLD,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;     // cycle within a half-period
  logic [HALF_W-1:0]     half_q, half_d;   // TRANSFER half-period index
  logic                  cpol_q, cpol_d;
  logic                  cpha_q, cpha_d;
  logic                  lsb_q, lsb_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;       // bits still to be shifted out
  logic [DATA_WIDTH-1:0] rx_q, rx_d;       // bits assembled so far
  logic [DATA_WIDTH-1:0] data_out_d;
  logic                  busy_d, done_d, mosi_d, sclk_d;
  logic [NUM_CS-1:0]     cs_d;
  logic                  rx_bit;

`ifdef SPI_LOOPBACK_EN
  logic loop_q, loop_d;
  assign rx_bit = loop_q ? MOSI : MISO;
`else
  assign rx_bit = MISO;
`endif

  // Bit that leaves first given the bit order.
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v,
                                     input logic lsb);
    return lsb ? v[0] : v[DATA_WIDTH-1];
  endfunction

  // Drop the bit just sent so the next one is at the output end.
  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] v,
                                                      input logic lsb);
    return lsb ? {1'b0, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], 1'b0};
  endfunction

  // RX assembles in the same order as TX, so the word is never reversed.
  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] v,
                                                     input logic b,
                                                     input logic lsb);
    return lsb ? {b, v[DATA_WIDTH-1:1]} : {v[DATA_WIDTH-2:0], b};
  endfunction

  // One-hot-low select; an index beyond the last output falls back to CS[0].
  function automatic logic [NUM_CS-1:0] cs_pattern(input logic [CS_SEL_W-1:0] sel);
    logic [NUM_CS-1:0] p;
    int                idx;
    idx = (int'(sel) < NUM_CS) ? int'(sel) : 0;
    for (int i = 0; i < NUM_CS; i++) p[i] = (i != idx);
    return p;
  endfunction

  always_comb begin
    logic odd_edge, do_shift, do_sample;
    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    div_d      = div_q;
    half_d     = half_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_out_d = data_out;
    busy_d     = busy;
    done_d     = done;
    mosi_d     = MOSI;
    sclk_d     = SCLK;
    cs_d       = CS;
    odd_edge   = 1'b0;
    do_shift   = 1'b0;
    do_sample  = 1'b0;
`ifdef SPI_LOOPBACK_EN
    loop_d     = loop_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
`ifdef SPI_LOOPBACK_EN
          loop_d  = loopback;
`endif
          div_d   = '0;
          rx_d    = '0;
          busy_d  = 1'b1;
          cs_d    = cs_pattern(cs_sel);
          sclk_d  = cpol;
          if (cpha) begin
            // First bit goes out on the first SCLK edge.
            mosi_d = 1'b0;
            tx_d   = data_in;
          end else begin
            // First bit must be valid before the first (sampling) edge.
            mosi_d = first_bit(data_in, lsb_first);
            tx_d   = shift_out(data_in, lsb_first);
          end
        end
      end

      S_SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = S_TRANSFER;
          div_d   = '0;
          half_d  = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_TRANSFER: begin
        if (div_q == DIV_LAST) begin
          // End of half-period k-1 is SCLK edge k; even half_q means odd k.
          div_d    = '0;
          sclk_d   = ~SCLK;
          odd_edge = ~half_q[0];
          if (odd_edge) begin
            do_shift  = cpha_q;
            do_sample = ~cpha_q;
          end else begin
            do_shift  = ~cpha_q && (half_q != HALF_LAST);
            do_sample = cpha_q;
          end
          if (do_shift) begin
            mosi_d = first_bit(tx_q, lsb_q);
            tx_d   = shift_out(tx_q, lsb_q);
          end
          if (do_sample) rx_d = shift_in(rx_q, rx_bit, lsb_q);
          if (half_q == HALF_LAST) state_d = S_HOLD;
          else                     half_d  = half_q + HALF_W'(1);
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_HOLD: begin
        if (div_q == DIV_LAST) begin
          state_d    = S_DONE;
          div_d      = '0;
          cs_d       = '1;
          done_d     = 1'b1;
          data_out_d = rx_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
        busy_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      half_q   <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      MOSI     <= 1'b0;
      SCLK     <= 1'b0;
      CS       <= '1;
`ifdef SPI_LOOPBACK_EN
      loop_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      half_q   <= half_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      lsb_q    <= lsb_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      data_out <= data_out_d;
      busy     <= busy_d;
      done     <= done_d;
      MOSI     <= mosi_d;
      SCLK     <= sclk_d;
      CS       <= cs_d;
`ifdef SPI_LOOPBACK_EN
      loop_q   <= loop_d;
`endif
    end
  end

endmodule
